// File: rtl/wb_regfile_scoreboard.sv
// Integer register file with a per-register pending-write scoreboard.
// Decode reads and hazard stalls are combinational; the write-back port retires pending marks.
module wb_regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] dec_rs1_addr_i,
  input  logic [ADDR_W-1:0] dec_rs2_addr_i,
  input  logic              dec_rs1_use_i,
  input  logic              dec_rs2_use_i,
  input  logic [ADDR_W-1:0] dec_rd_addr_i,
  input  logic              dec_rd_write_i,
  input  logic              dec_issue_i,
  output logic [XLEN-1:0]   dec_rs1_data_o,
  output logic [XLEN-1:0]   dec_rs2_data_o,
  output logic              dec_stall_o,
  input  logic              wb_write_enable_i,
  input  logic [ADDR_W-1:0] wb_write_addr_i,
  input  logic [XLEN-1:0]   wb_write_data_i,
  output logic [NREGS-1:0]  busy_mask_o,
  output logic              sb_err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [CNT_W-1:0] cnt_q  [NREGS];
  logic             sb_err_q;

  logic [NREGS-1:0] wb_hit;
  logic [NREGS-1:0] inc_hit;
  logic [NREGS-1:0] cnt_zero;
  logic             rs1_pend;
  logic             rs2_pend;
  logic             rd_sat;
  logic             accept;

  // One-hot write-back decode; x0 never decodes so it is never written or retired.
  always_comb begin
    wb_hit = '0;
    if (wb_write_enable_i && (wb_write_addr_i != '0))
      wb_hit[wb_write_addr_i] = 1'b1;
  end

  always_comb begin
    cnt_zero = '0;
    for (int r = 0; r < NREGS; r++)
      cnt_zero[r] = (cnt_q[r] == '0);
  end

  // A same-cycle write-back retiring the last pending write clears the hazard.
  always_comb begin
    rs1_pend = 1'b0;
    rs2_pend = 1'b0;
    rd_sat   = 1'b0;
    if (dec_rs1_addr_i != '0)
      rs1_pend = !cnt_zero[dec_rs1_addr_i] &&
                 !(wb_hit[dec_rs1_addr_i] && (cnt_q[dec_rs1_addr_i] == CNT_ONE));
    if (dec_rs2_addr_i != '0)
      rs2_pend = !cnt_zero[dec_rs2_addr_i] &&
                 !(wb_hit[dec_rs2_addr_i] && (cnt_q[dec_rs2_addr_i] == CNT_ONE));
    if (dec_rd_addr_i != '0)
      rd_sat = (cnt_q[dec_rd_addr_i] == CNT_MAX) && !wb_hit[dec_rd_addr_i];
  end

  always_comb begin
    dec_stall_o = dec_issue_i && ((dec_rs1_use_i && rs1_pend) ||
                                  (dec_rs2_use_i && rs2_pend) ||
                                  (dec_rd_write_i && rd_sat));
    accept      = dec_issue_i && !dec_stall_o;
  end

  always_comb begin
    inc_hit = '0;
    if (accept && dec_rd_write_i && (dec_rd_addr_i != '0))
      inc_hit[dec_rd_addr_i] = 1'b1;
  end

  always_comb begin
    if (dec_rs1_addr_i == '0)
      dec_rs1_data_o = '0;
    else if (wb_write_enable_i && (wb_write_addr_i == dec_rs1_addr_i))
      dec_rs1_data_o = wb_write_data_i;
    else
      dec_rs1_data_o = regs_q[dec_rs1_addr_i];
  end

  always_comb begin
    if (dec_rs2_addr_i == '0)
      dec_rs2_data_o = '0;
    else if (wb_write_enable_i && (wb_write_addr_i == dec_rs2_addr_i))
      dec_rs2_data_o = wb_write_data_i;
    else
      dec_rs2_data_o = regs_q[dec_rs2_addr_i];
  end

  // Saturation stall guarantees an accepted increment never wraps the counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (wb_hit[r])
          regs_q[r] <= wb_write_data_i;
        case ({inc_hit[r], wb_hit[r]})
          2'b10:   cnt_q[r] <= cnt_q[r] + CNT_ONE;
          2'b01:   if (!cnt_zero[r]) cnt_q[r] <= cnt_q[r] - CNT_ONE;
          default: cnt_q[r] <= cnt_q[r];
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      sb_err_q <= 1'b0;
    else if (|(wb_hit & cnt_zero))
      sb_err_q <= 1'b1;
  end

  always_comb begin
    busy_mask_o = ~cnt_zero;
    busy_mask_o[0] = 1'b0;
  end

  assign sb_err_o = sb_err_q;

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Bench for wb_regfile_scoreboard: a table of per-cycle vectors checked through an
// expectation queue, plus a hand-written asynchronous reset sequence.
module tb_wb_regfile_scoreboard;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  dec_rs1_addr_i, dec_rs2_addr_i, dec_rd_addr_i, wb_write_addr_i;
  logic        dec_rs1_use_i, dec_rs2_use_i, dec_rd_write_i, dec_issue_i, wb_write_enable_i;
  logic [31:0] wb_write_data_i, dec_rs1_data_o, dec_rs2_data_o, busy_mask_o;
  logic        dec_stall_o, sb_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  wb_regfile_scoreboard dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dec_rs1_addr_i(dec_rs1_addr_i), .dec_rs2_addr_i(dec_rs2_addr_i),
    .dec_rs1_use_i(dec_rs1_use_i), .dec_rs2_use_i(dec_rs2_use_i),
    .dec_rd_addr_i(dec_rd_addr_i), .dec_rd_write_i(dec_rd_write_i),
    .dec_issue_i(dec_issue_i),
    .dec_rs1_data_o(dec_rs1_data_o), .dec_rs2_data_o(dec_rs2_data_o),
    .dec_stall_o(dec_stall_o),
    .wb_write_enable_i(wb_write_enable_i), .wb_write_addr_i(wb_write_addr_i),
    .wb_write_data_i(wb_write_data_i),
    .busy_mask_o(busy_mask_o), .sb_err_o(sb_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        issue;
    logic [4:0]  rs1; logic use1;
    logic [4:0]  rs2; logic use2;
    logic [4:0]  rd;  logic rdw;
    logic        wbe; logic [4:0] wba; logic [31:0] wbd;
    logic        e_stall;
    logic [31:0] e_d1, e_d2, e_busy;
    logic        e_err;
  } vec_t;

  typedef struct {
    string       name;
    logic        stall;
    logic [31:0] d1, d2, busy;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  function automatic vec_t mk(string name, logic issue,
                              logic [4:0] rs1, logic use1, logic [4:0] rs2, logic use2,
                              logic [4:0] rd, logic rdw,
                              logic wbe, logic [4:0] wba, logic [31:0] wbd,
                              logic e_stall, logic [31:0] e_d1, logic [31:0] e_d2,
                              logic [31:0] e_busy, logic e_err);
    vec_t v;
    v.name = name; v.issue = issue;
    v.rs1 = rs1; v.use1 = use1; v.rs2 = rs2; v.use2 = use2;
    v.rd = rd; v.rdw = rdw; v.wbe = wbe; v.wba = wba; v.wbd = wbd;
    v.e_stall = e_stall; v.e_d1 = e_d1; v.e_d2 = e_d2; v.e_busy = e_busy; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.name, ".stall"}, {31'b0, dec_stall_o}, {31'b0, e.stall});
      chk({e.name, ".rs1"},   dec_rs1_data_o, e.d1);
      chk({e.name, ".rs2"},   dec_rs2_data_o, e.d2);
      chk({e.name, ".busy"},  busy_mask_o, e.busy);
      chk({e.name, ".err"},   {31'b0, sb_err_o}, {31'b0, e.err});
    end
  end

  task automatic apply(input vec_t v);
    exp_t e;
    @(posedge clk_i);
    #1;
    dec_issue_i = v.issue;
    dec_rs1_addr_i = v.rs1; dec_rs1_use_i = v.use1;
    dec_rs2_addr_i = v.rs2; dec_rs2_use_i = v.use2;
    dec_rd_addr_i = v.rd;   dec_rd_write_i = v.rdw;
    wb_write_enable_i = v.wbe; wb_write_addr_i = v.wba; wb_write_data_i = v.wbd;
    e.name = v.name; e.stall = v.e_stall; e.d1 = v.e_d1; e.d2 = v.e_d2;
    e.busy = v.e_busy; e.err = v.e_err;
    exp_q.push_back(e);
    @(negedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    dec_issue_i = 0; dec_rs1_addr_i = 0; dec_rs1_use_i = 0; dec_rs2_addr_i = 0;
    dec_rs2_use_i = 0; dec_rd_addr_i = 0; dec_rd_write_i = 0;
    wb_write_enable_i = 0; wb_write_addr_i = 0; wb_write_data_i = 0;

    //              name          iss rs1 u1 rs2 u2 rd w  wbe wba wbd            stall d1            d2            busy          err
    vecs.push_back(mk("idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        32'h0,        32'h0,        0));
    vecs.push_back(mk("iss_x3",     1, 0, 0, 0, 0, 3, 1, 0, 0, 32'h0,         0, 32'h0,        32'h0,        32'h0,        0));
    vecs.push_back(mk("raw_stall",  1, 3, 1, 0, 0, 0, 0, 0, 0, 32'h0,         1, 32'h0,        32'h0,        32'h8,        0));
    vecs.push_back(mk("raw_bypass", 1, 3, 1, 0, 0, 0, 0, 1, 3, 32'hDEADBEEF,  0, 32'hDEADBEEF, 32'h0,        32'h8,        0));
    vecs.push_back(mk("x3_array",   0, 3, 0, 3, 0, 0, 0, 0, 0, 32'h0,         0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        0));
    vecs.push_back(mk("waw_1",      1, 0, 0, 0, 0, 7, 1, 0, 0, 32'h0,         0, 32'h0,        32'h0,        32'h0,        0));
    vecs.push_back(mk("waw_2",      1, 0, 0, 0, 0, 7, 1, 0, 0, 32'h0,         0, 32'h0,        32'h0,        32'h80,       0));
    vecs.push_back(mk("waw_3",      1, 0, 0, 0, 0, 7, 1, 0, 0, 32'h0,         0, 32'h0,        32'h0,        32'h80,       0));
    vecs.push_back(mk("waw_sat",    1, 0, 0, 0, 0, 7, 1, 0, 0, 32'h0,         1, 32'h0,        32'h0,        32'h80,       0));
    vecs.push_back(mk("waw_sat_wb", 1, 0, 0, 0, 0, 7, 1, 1, 7, 32'h77,        0, 32'h0,        32'h0,        32'h80,       0));
    vecs.push_back(mk("waw_still",  1, 7, 0, 7, 0, 7, 1, 0, 0, 32'h0,         1, 32'h77,       32'h77,       32'h80,       0));
    vecs.push_back(mk("drain_1",    0, 7, 0, 0, 0, 0, 0, 1, 7, 32'h71,        0, 32'h71,       32'h0,        32'h80,       0));
    vecs.push_back(mk("rs2_eff2",   1, 7, 0, 7, 1, 0, 0, 1, 7, 32'h72,        1, 32'h72,       32'h72,       32'h80,       0));
    vecs.push_back(mk("rs2_eff0",   1, 7, 0, 7, 1, 0, 0, 1, 7, 32'h73,        0, 32'h73,       32'h73,       32'h80,       0));
    vecs.push_back(mk("x7_done",    0, 7, 0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h73,       32'h0,        32'h0,        0));
    vecs.push_back(mk("x0_iss_wb",  1, 0, 1, 0, 1, 0, 1, 1, 0, 32'h1234,      0, 32'h0,        32'h0,        32'h0,        0));
    vecs.push_back(mk("x0_after",   0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        32'h0,        32'h0,        0));
    vecs.push_back(mk("uflow_wb",   0, 9, 0, 0, 0, 0, 0, 1, 9, 32'h99,        0, 32'h99,       32'h0,        32'h0,        0));
    vecs.push_back(mk("uflow_err",  0, 9, 0, 9, 0, 0, 0, 0, 0, 32'h0,         0, 32'h99,       32'h99,       32'h0,        1));
    vecs.push_back(mk("err_sticky", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,        32'h0,        32'h0,        1));
    vecs.push_back(mk("sim_iss",    1, 0, 0, 0, 0, 4, 1, 0, 0, 32'h0,         0, 32'h0,        32'h0,        32'h0,        1));
    vecs.push_back(mk("sim_both",   1, 0, 0, 0, 0, 4, 1, 1, 4, 32'h44,        0, 32'h0,        32'h0,        32'h10,       1));
    vecs.push_back(mk("sim_after",  0, 4, 0, 4, 0, 0, 0, 0, 0, 32'h0,         0, 32'h44,       32'h44,       32'h10,       1));
    vecs.push_back(mk("x5_iss",     1, 0, 0, 0, 0, 5, 1, 0, 0, 32'h0,         0, 32'h0,        32'h0,        32'h10,       1));
    vecs.push_back(mk("x5_iss_wb",  1, 0, 0, 0, 0, 5, 1, 1, 5, 32'h55,        0, 32'h0,        32'h0,        32'h30,       1));
    vecs.push_back(mk("x5_busy",    0, 5, 0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h55,       32'h0,        32'h30,       1));

    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i]);

    // Mid-run asynchronous reset with x5 busy and written.
    dec_issue_i = 1; dec_rs1_addr_i = 5; dec_rs1_use_i = 1; dec_rd_addr_i = 5; dec_rd_write_i = 1;
    rst_i = 1'b1;
    #1;
    chk("rst.busy",  busy_mask_o, 32'h0);
    chk("rst.rs1",   dec_rs1_data_o, 32'h0);
    chk("rst.err",   {31'b0, sb_err_o}, 32'h0);
    chk("rst.stall", {31'b0, dec_stall_o}, 32'h0);
    dec_issue_i = 0;
    wb_write_enable_i = 1; wb_write_addr_i = 6; wb_write_data_i = 32'hABC;
    @(posedge clk_i);
    #1;
    wb_write_enable_i = 0; dec_rs1_addr_i = 6;
    #1;
    chk("rst.wb_ignored", dec_rs1_data_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    apply(mk("post_rst",  1, 5, 1, 0, 0, 6, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0,  0));
    apply(mk("post_rst2", 0, 5, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h40, 0));

    chk("sb_drained", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
